mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle control FSM for the MIPS core. It decodes the latched instruction fields and drives every datapath strobe, including the 6-bit `alu_control` code the ALU consumes. It sequences fetch, decode, execute, memory and write-back, and stalls on a memory ready handshake. It sits between the instruction register and the datapath muxes, register file, PC and memory port.

## Interface
- No parameters.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; stable from the cycle after the FETCH handshake.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `alu_control`  out  6  ALU op code: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, NOR 100111, XOR 100110, SLL 000000, SRL 000010, SRA 000011.
- `alu_src_a`  out  2  A-operand select: 00 PC, 01 rs reg, 10 rt reg.
- `alu_src_b`  out  3  B-operand select: 000 rt reg, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 zero-ext shamt, 101 zero-ext imm.
- `pc_source`  out  2  PC input select: 00 ALU result, 01 ALUOut, 10 jump target.
- `pc_en`  out  1  PC load enable.
- `i_or_d`  out  1  memory address select: 0 PC, 1 ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  IR load enable.
- `reg_write`  out  1  register-file write enable.
- `reg_dst`  out  1  destination select: 0 rt, 1 rd.
- `mem_to_reg`  out  1  write-data select: 0 ALUOut, 1 MDR.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4  current state encoding, for debug.

## Operation
- State encodings: BOOT 12, FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11. Encodings 13–15 go to BOOT.
- Outputs are Moore-decoded from the state register. Exceptions: `pc_en`, `ir_write` and `illegal` also use inputs. All outputs not listed for a state are 0.
- BOOT: all outputs 0. Next state is FETCH.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=00, `alu_src_b`=001, `alu_control`=ADD, `pc_source`=00. `ir_write` and `pc_en` equal `mem_ready`. Stay while `mem_ready`=0; go to DECODE when `mem_ready`=1.
- DECODE: `alu_src_a`=00, `alu_src_b`=011, ADD, which places the branch target in ALUOut. Next state by opcode:
  - 0x00 with a listed funct → R_EXEC.
  - 0x23 or 0x2B → MEM_ADDR.
  - 0x04 or 0x05 → BRANCH.
  - 0x02 → JUMP.
  - 0x08, 0x0A, 0x0C or 0x0D → I_EXEC.
  - Anything else → FETCH, with `illegal`=1 for this cycle.
- MEM_ADDR: `alu_src_a`=01, `alu_src_b`=010, ADD. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Then FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1. Hold until `mem_ready`, then go to FETCH.
- R_EXEC: `alu_control`=`funct`. Operand selects:
  - Shifts (funct 000000/000010/000011): `alu_src_a`=10, `alu_src_b`=100.
  - All other funct: `alu_src_a`=01, `alu_src_b`=000.
  - Next state is R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Then FETCH.
- BRANCH: `alu_src_a`=01, `alu_src_b`=000, SUB, `pc_source`=01. `pc_en` = `zero` for beq, `!zero` for bne. Then FETCH.
- JUMP: `pc_en`=1, `pc_source`=10. Then FETCH.
- I_EXEC: `alu_src_a`=01. Per opcode:
  - addi: `alu_src_b`=010, ADD.
  - slti: `alu_src_b`=010, SLT.
  - andi: `alu_src_b`=101, AND.
  - ori: `alu_src_b`=101, OR.
  - Next state is I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Then FETCH.
- `mem_read` and `mem_write` are never high together.
- `mem_read`/`mem_write` stay high, and the address selection stays stable, until `mem_ready` is sampled high.

## Timing
- `rst_n` low: state goes to BOOT immediately, without a clock edge. All outputs read 0 while `rst_n` is low. This also holds when reset asserts mid-instruction, including mid-stall.
- After `rst_n` rises: the first edge moves BOOT→FETCH.
- Cycles per instruction with zero-wait memory (`mem_ready` always 1): lw 5, sw 4, R-type 4, I-type 4, beq/bne 3, j 3.
- Each wait cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- A `mem_ready` pulse outside FETCH, MEM_READ and MEM_WRITE is ignored.
- `pc_en` in BRANCH follows `zero` combinationally within the same cycle.

## Test plan
- Reset: pulse `rst_n` low mid-MEM_READ → `state`=12 and all outputs 0 asynchronously. The first edge after release gives `state`=0 with `mem_read`=1.
- add: opcode 0x00, funct 0x20, `mem_ready`=1 → states 0,1,6,7,0.
  - `alu_control`=100000 in R_EXEC.
  - `reg_write`=1 and `reg_dst`=1 in R_WB only.
- lw with a 2-cycle wait in MEM_READ → states 0,1,2,3,3,3,4,0. `mem_to_reg`=1 in MEM_WB.
- beq and bne: beq with `zero`=1 → `pc_en`=1 in BRANCH. beq with `zero`=0 → `pc_en`=0. bne inverts both results.
- sra: funct 0x03 → in R_EXEC, `alu_src_a`=10, `alu_src_b`=100, `alu_control`=000011.
- Illegal: opcode 0x3F → `illegal`=1 in DECODE only, then FETCH. No `reg_write` or `mem_write` is asserted.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back and
// Moore-decodes every datapath strobe from the state register.
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [5:0] alu_control,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StIExec    = 4'd10,
    StIWb      = 4'd11,
    StBoot     = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] AluAdd = 6'b100000;
  localparam logic [5:0] AluSub = 6'b100010;
  localparam logic [5:0] AluAnd = 6'b100100;
  localparam logic [5:0] AluOr  = 6'b100101;
  localparam logic [5:0] AluSlt = 6'b101010;

  state_e state_q, state_d;
  logic   funct_legal, funct_shift;

  always_comb begin
    funct_legal = 1'b0;
    funct_shift = 1'b0;
    case (funct)
      6'h00, 6'h02, 6'h03: begin
        funct_legal = 1'b1;
        funct_shift = 1'b1;
      end
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: funct_legal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    alu_control = 6'b000000;
    alu_src_a   = 2'b00;
    alu_src_b   = 3'b000;
    pc_source   = 2'b00;
    pc_en       = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        mem_read    = 1'b1;
        alu_src_b   = 3'b001;
        alu_control = AluAdd;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Branch target is computed here speculatively into ALUOut.
        alu_src_b   = 3'b011;
        alu_control = AluAdd;
        case (opcode)
          OpRtype: begin
            if (funct_legal) begin
              state_d = StRExec;
            end else begin
              state_d = StFetch;
              illegal = 1'b1;
            end
          end
          OpLw, OpSw:                     state_d = StMemAddr;
          OpBeq, OpBne:                   state_d = StBranch;
          OpJ:                            state_d = StJump;
          OpAddi, OpSlti, OpAndi, OpOri:  state_d = StIExec;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 3'b010;
        alu_control = AluAdd;
        state_d     = (opcode == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StRExec: begin
        alu_control = funct;
        alu_src_a   = funct_shift ? 2'b10 : 2'b01;
        alu_src_b   = funct_shift ? 3'b100 : 3'b000;
        state_d     = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a   = 2'b01;
        alu_control = AluSub;
        pc_source   = 2'b01;
        pc_en       = (opcode == OpBeq) ? zero : !zero;
        state_d     = StFetch;
      end
      StJump: begin
        pc_en     = 1'b1;
        pc_source = 2'b10;
        state_d   = StFetch;
      end
      StIExec: begin
        alu_src_a = 2'b01;
        case (opcode)
          OpSlti: begin
            alu_src_b   = 3'b010;
            alu_control = AluSlt;
          end
          OpAndi: begin
            alu_src_b   = 3'b101;
            alu_control = AluAnd;
          end
          OpOri: begin
            alu_src_b   = 3'b101;
            alu_control = AluOr;
          end
          default: begin
            alu_src_b   = 3'b010;
            alu_control = AluAdd;
          end
        endcase
        state_d = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-cycle vector table fed through an expected-value queue, plus
// hand-driven asynchronous reset in the middle of a memory stall.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] alu_control;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] state;

  mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_control(alu_control),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [21:0] out;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [21:0] out;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [21:0] act;
  assign act = {alu_control, alu_src_a, alu_src_b, pc_source, pc_en, i_or_d, mem_read,
                mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal};

  // flags: {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal}
  function automatic logic [21:0] eo(logic [5:0] alu, logic [1:0] sa, logic [2:0] sbs,
                                     logic [1:0] ps, logic [8:0] flags);
    return {alu, sa, sbs, ps, flags};
  endfunction

  task automatic v(input logic [5:0] op, input logic [5:0] fn, input logic z,
                   input logic rdy, input logic [3:0] st, input logic [21:0] out);
    vec_t r;
    r.op = op; r.fn = fn; r.z = z; r.rdy = rdy; r.st = st; r.out = out;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [3:0] st, input logic [21:0] out);
    n_vec++;
    if ({state, act} !== {st, out}) begin
      n_err++;
      $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
               name, state, act, st, out);
    end
  endtask

  localparam logic [5:0] Add = 6'b100000;
  localparam logic [5:0] Sub = 6'b100010;

  logic [21:0] o_f1, o_f0, o_d, o_di, o_ma, o_mr, o_mwb, o_mw, o_rwb, o_iwb, o_j;
  logic [21:0] o_br1, o_br0;

  initial begin
    o_f1  = eo(Add, 2'b00, 3'b001, 2'b00, 9'b101010000);
    o_f0  = eo(Add, 2'b00, 3'b001, 2'b00, 9'b001000000);
    o_d   = eo(Add, 2'b00, 3'b011, 2'b00, 9'b000000000);
    o_di  = eo(Add, 2'b00, 3'b011, 2'b00, 9'b000000001);
    o_ma  = eo(Add, 2'b01, 3'b010, 2'b00, 9'b000000000);
    o_mr  = eo(6'd0, 2'b00, 3'b000, 2'b00, 9'b011000000);
    o_mwb = eo(6'd0, 2'b00, 3'b000, 2'b00, 9'b000001010);
    o_mw  = eo(6'd0, 2'b00, 3'b000, 2'b00, 9'b010100000);
    o_rwb = eo(6'd0, 2'b00, 3'b000, 2'b00, 9'b000001100);
    o_iwb = eo(6'd0, 2'b00, 3'b000, 2'b00, 9'b000001000);
    o_j   = eo(6'd0, 2'b00, 3'b000, 2'b10, 9'b100000000);
    o_br1 = eo(Sub, 2'b01, 3'b000, 2'b01, 9'b100000000);
    o_br0 = eo(Sub, 2'b01, 3'b000, 2'b01, 9'b000000000);

    // add: 0,1,6,7
    v(6'h00, 6'h20, 0, 1, 4'd0, o_f1);
    v(6'h00, 6'h20, 0, 1, 4'd1, o_d);
    v(6'h00, 6'h20, 0, 1, 4'd6, eo(Add, 2'b01, 3'b000, 2'b00, 9'd0));
    v(6'h00, 6'h20, 0, 1, 4'd7, o_rwb);
    // lw: one fetch wait, two MEM_READ waits; mem_ready low in MEM_WB is irrelevant
    v(6'h23, 6'h00, 0, 0, 4'd0, o_f0);
    v(6'h23, 6'h00, 0, 1, 4'd0, o_f1);
    v(6'h23, 6'h00, 0, 1, 4'd1, o_d);
    v(6'h23, 6'h00, 0, 1, 4'd2, o_ma);
    v(6'h23, 6'h00, 0, 0, 4'd3, o_mr);
    v(6'h23, 6'h00, 0, 0, 4'd3, o_mr);
    v(6'h23, 6'h00, 0, 1, 4'd3, o_mr);
    v(6'h23, 6'h00, 0, 0, 4'd4, o_mwb);
    // sw: one MEM_WRITE wait; mem_ready low in MEM_ADDR does not stall
    v(6'h2B, 6'h00, 0, 1, 4'd0, o_f1);
    v(6'h2B, 6'h00, 0, 1, 4'd1, o_d);
    v(6'h2B, 6'h00, 0, 0, 4'd2, o_ma);
    v(6'h2B, 6'h00, 0, 0, 4'd5, o_mw);
    v(6'h2B, 6'h00, 0, 1, 4'd5, o_mw);
    // beq/bne with both zero values
    v(6'h04, 6'h00, 1, 1, 4'd0, o_f1);
    v(6'h04, 6'h00, 1, 1, 4'd1, o_d);
    v(6'h04, 6'h00, 1, 1, 4'd8, o_br1);
    v(6'h04, 6'h00, 0, 1, 4'd0, o_f1);
    v(6'h04, 6'h00, 0, 1, 4'd1, o_d);
    v(6'h04, 6'h00, 0, 1, 4'd8, o_br0);
    v(6'h05, 6'h00, 1, 1, 4'd0, o_f1);
    v(6'h05, 6'h00, 1, 1, 4'd1, o_d);
    v(6'h05, 6'h00, 1, 1, 4'd8, o_br0);
    v(6'h05, 6'h00, 0, 1, 4'd0, o_f1);
    v(6'h05, 6'h00, 0, 1, 4'd1, o_d);
    v(6'h05, 6'h00, 0, 1, 4'd8, o_br1);
    // j
    v(6'h02, 6'h00, 0, 1, 4'd0, o_f1);
    v(6'h02, 6'h00, 0, 1, 4'd1, o_d);
    v(6'h02, 6'h00, 0, 1, 4'd9, o_j);
    // sra and xor
    v(6'h00, 6'h03, 0, 1, 4'd0, o_f1);
    v(6'h00, 6'h03, 0, 1, 4'd1, o_d);
    v(6'h00, 6'h03, 0, 1, 4'd6, eo(6'b000011, 2'b10, 3'b100, 2'b00, 9'd0));
    v(6'h00, 6'h03, 0, 1, 4'd7, o_rwb);
    v(6'h00, 6'h26, 0, 1, 4'd0, o_f1);
    v(6'h00, 6'h26, 0, 1, 4'd1, o_d);
    v(6'h00, 6'h26, 0, 1, 4'd6, eo(6'b100110, 2'b01, 3'b000, 2'b00, 9'd0));
    v(6'h00, 6'h26, 0, 1, 4'd7, o_rwb);
    // I-type
    v(6'h08, 6'h00, 0, 1, 4'd0, o_f1);
    v(6'h08, 6'h00, 0, 1, 4'd1, o_d);
    v(6'h08, 6'h00, 0, 1, 4'd10, eo(Add, 2'b01, 3'b010, 2'b00, 9'd0));
    v(6'h08, 6'h00, 0, 1, 4'd11, o_iwb);
    v(6'h0A, 6'h00, 0, 1, 4'd0, o_f1);
    v(6'h0A, 6'h00, 0, 1, 4'd1, o_d);
    v(6'h0A, 6'h00, 0, 1, 4'd10, eo(6'b101010, 2'b01, 3'b010, 2'b00, 9'd0));
    v(6'h0A, 6'h00, 0, 1, 4'd11, o_iwb);
    v(6'h0C, 6'h00, 0, 1, 4'd0, o_f1);
    v(6'h0C, 6'h00, 0, 1, 4'd1, o_d);
    v(6'h0C, 6'h00, 0, 1, 4'd10, eo(6'b100100, 2'b01, 3'b101, 2'b00, 9'd0));
    v(6'h0C, 6'h00, 0, 1, 4'd11, o_iwb);
    v(6'h0D, 6'h00, 0, 1, 4'd0, o_f1);
    v(6'h0D, 6'h00, 0, 1, 4'd1, o_d);
    v(6'h0D, 6'h00, 0, 1, 4'd10, eo(6'b100101, 2'b01, 3'b101, 2'b00, 9'd0));
    v(6'h0D, 6'h00, 0, 1, 4'd11, o_iwb);
    // illegal opcode, then illegal funct: back to FETCH with nothing written
    v(6'h3F, 6'h00, 0, 1, 4'd0, o_f1);
    v(6'h3F, 6'h00, 0, 1, 4'd1, o_di);
    v(6'h00, 6'h3F, 0, 1, 4'd0, o_f1);
    v(6'h00, 6'h3F, 0, 1, 4'd1, o_di);
    v(6'h23, 6'h00, 0, 1, 4'd0, o_f1);

    // Reset state, with mem_ready high so any leak would show
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset_idle", 4'd12, 22'd0);
    @(negedge clk);
    check("reset_idle2", 4'd12, 22'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      exp_t e;
      @(posedge clk);
      #1;
      opcode    = vecs[i].op;
      funct     = vecs[i].fn;
      zero      = vecs[i].z;
      mem_ready = vecs[i].rdy;
      e.st = vecs[i].st; e.out = vecs[i].out; e.idx = i;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: got empty queue, expected entry %0d", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d", e.idx), e.st, e.out);
      end
    end

    // Table ends in FETCH for lw; walk into a MEM_READ stall and reset there
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("lw_stall", 4'd3, o_mr);
    @(posedge clk); #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("reset_async", 4'd12, 22'd0);
    @(posedge clk); #1;
    check("reset_hold", 4'd12, 22'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_fetch", 4'd0, o_f1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
